// File: rtl/mul_div_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_pkg
//   Shared definitions for the mul_div unit: sequencer state encoding and the
//   byte-pair counts used by the iterative multiplier.
//
//   MUL_PAIRS      : number of 8x8 byte pairs in a full 32x32 product
//   MUL_LOW_LAST   : counter value of the final pair when only the low word
//                    is needed (used when MUL_FAST_LOW_EN is defined)
//   MUL_FAST_PAIRS : number of pairs visited on the low-word fast path
// ---------------------------------------------------------------------------
package mul_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mul_state_e;

    localparam int MUL_PAIRS      = 16;
    localparam int MUL_LOW_LAST   = 12;
    localparam int MUL_FAST_PAIRS = 10;

endpackage : mul_div_pkg

// File: rtl/wallace_8x8_product.sv
// ---------------------------------------------------------------------------
// wallace_8x8_product
//   Combinational unsigned 8x8 -> 16-bit multiplier. The eight AND-gated
//   partial-product rows are reduced with 3:2 carry-save compressors down to
//   two rows, which a single carry-propagate adder then sums.
//
//   Ports:
//     a_i  in  8   multiplicand byte
//     b_i  in  8   multiplier byte
//     p_o  out 16  product a_i * b_i
// ---------------------------------------------------------------------------
module wallace_8x8_product (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    logic [15:0] pp [8];

    // One shifted partial-product row per multiplier bit.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp
        assign pp[gi] = {8'b0, a_i & {8{b_i[gi]}}} << gi;
    end

    // Carry-save tree. Everything is kept modulo 2^16; the true product
    // never exceeds 16 bits, so carries dropped off the top are always zero.
    logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    assign s0 = pp[0] ^ pp[1] ^ pp[2];
    assign c0 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    assign s1 = pp[3] ^ pp[4] ^ pp[5];
    assign c1 = ((pp[3] & pp[4]) | (pp[3] & pp[5]) | (pp[4] & pp[5])) << 1;

    assign s2 = s0 ^ c0 ^ s1;
    assign c2 = ((s0 & c0) | (s0 & s1) | (c0 & s1)) << 1;
    assign s3 = c1 ^ pp[6] ^ pp[7];
    assign c3 = ((c1 & pp[6]) | (c1 & pp[7]) | (pp[6] & pp[7])) << 1;

    assign s4 = s2 ^ c2 ^ s3;
    assign c4 = ((s2 & c2) | (s2 & s3) | (c2 & s3)) << 1;

    assign s5 = s4 ^ c4 ^ c3;
    assign c5 = ((s4 & c4) | (s4 & c3) | (c4 & c3)) << 1;

    assign p_o = s5 + c5;

endmodule : wallace_8x8_product

// File: rtl/mul32_seq_byte.sv
// ---------------------------------------------------------------------------
// mul32_seq_byte
//   Iterative RV32M multiplier (MUL / MULH / MULHSU / MULHU). Operands are
//   converted to magnitudes at accept, then one byte pair per cycle is fed
//   through an 8x8 product unit and accumulated into a 64-bit sum. A final
//   FIX cycle re-applies the sign and selects the requested word.
//
//   Latency: 18 cycles from accept to valid_o (12 for low-word results when
//   the optional fast path is compiled in).
//
//   Build option:
//     MUL_FAST_LOW_EN - when the latched high flag is 0, skip the byte pairs
//                       whose shifted product lies entirely above bit 31.
//
//   Ports:
//     clk_i       in  1     core clock
//     rst_ni      in  1     asynchronous active-low reset
//     start_i     in  1     request, accepted only when busy_o=0
//     kill_i      in  1     pipeline flush, aborts any operation in flight
//     op_a_i      in  32    multiplicand (rs1)
//     op_b_i      in  32    multiplier (rs2)
//     a_signed_i  in  1     op_a_i is two's complement
//     b_signed_i  in  1     op_b_i is two's complement
//     high_i      in  1     1 -> product[63:32], 0 -> product[31:0]
//     busy_o      out 1     high in CALC or FIX
//     valid_o     out 1     one-cycle result strobe
//     result_o    out 32    result, held until overwritten by a later FIX
// ---------------------------------------------------------------------------
module mul32_seq_byte
    import mul_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            a_signed_i,
    input  logic            b_signed_i,
    input  logic            high_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    if (XLEN != 32) begin : g_xlen_check
        $error("mul32_seq_byte: only XLEN=32 is supported");
    end

    mul_state_e  state_q;
    logic [3:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] ua_q;
    logic [31:0] ub_q;
    logic        neg_q;
    logic        high_q;
    logic        valid_q;
    logic [31:0] result_q;

    // ---------------- operand conditioning at accept ----------------
    logic        a_neg_in, b_neg_in;
    logic [31:0] ua_d, ub_d;
    logic        neg_d;

    assign a_neg_in = a_signed_i & op_a_i[31];
    assign b_neg_in = b_signed_i & op_b_i[31];
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    assign ua_d     = a_neg_in ? (32'd0 - op_a_i) : op_a_i;
    assign ub_d     = b_neg_in ? (32'd0 - op_b_i) : op_b_i;
    assign neg_d    = a_neg_in ^ b_neg_in;

    // ---------------- byte-pair datapath ----------------
    logic [1:0]  idx_i, idx_j;
    logic [2:0]  ij_sum;
    logic [7:0]  byte_a, byte_b;
    logic [15:0] pair_prod;
    logic [63:0] pair_shifted;
    logic [63:0] acc_d;
    logic [63:0] prod_fix;

    assign idx_i  = cnt_q[1:0];
    assign idx_j  = cnt_q[3:2];
    assign ij_sum = {1'b0, idx_i} + {1'b0, idx_j};
    assign byte_a = ua_q[{idx_i, 3'b000} +: 8];
    assign byte_b = ub_q[{idx_j, 3'b000} +: 8];

    wallace_8x8_product u_wallace (
        .a_i (byte_a),
        .b_i (byte_b),
        .p_o (pair_prod)
    );

    assign pair_shifted = {48'd0, pair_prod} << {ij_sum, 3'b000};
    assign acc_d        = acc_q + pair_shifted;
    assign prod_fix     = neg_q ? (64'd0 - acc_q) : acc_q;

    // ---------------- pair sequencing ----------------
    logic       last_pair;
    logic [3:0] cnt_d;

`ifdef MUL_FAST_LOW_EN
    logic row_done;

    // On a low-word request, pairs with i+j>3 land at bit 32 or above, so
    // once i+j reaches 3 the rest of the row is skipped.
    assign row_done  = !high_q && (ij_sum == 3'd3) && (idx_j != 2'd3);
    assign last_pair = high_q ? (cnt_q == 4'(MUL_PAIRS - 1))
                              : (cnt_q == 4'(MUL_LOW_LAST));
    assign cnt_d     = row_done ? {idx_j + 2'd1, 2'b00} : (cnt_q + 4'd1);
`else
    assign last_pair = (cnt_q == 4'(MUL_PAIRS - 1));
    assign cnt_d     = cnt_q + 4'd1;
`endif

    // ---------------- sequencer ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            ua_q     <= '0;
            ub_q     <= '0;
            neg_q    <= 1'b0;
            high_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (kill_i) begin
                // Flush beats everything, including a coincident start.
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            ua_q    <= ua_d;
                            ub_q    <= ub_d;
                            neg_q   <= neg_d;
                            high_q  <= high_i;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                    CALC: begin
                        acc_q <= acc_d;
                        if (last_pair) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    FIX: begin
                        result_q <= high_q ? prod_fix[63:32] : prod_fix[31:0];
                        valid_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule : mul32_seq_byte

// File: tb/tb_mul32_seq_byte.sv
// ---------------------------------------------------------------------------
// tb_mul32_seq_byte
//   Directed and randomized checks of mul32_seq_byte against a plain 64-bit
//   arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mul32_seq_byte;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        kill_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        a_signed_i;
    logic        b_signed_i;
    logic        high_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'd0;

    always #5 clk_i = ~clk_i;

    mul32_seq_byte #(.XLEN(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .kill_i     (kill_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .a_signed_i (a_signed_i),
        .b_signed_i (b_signed_i),
        .high_i     (high_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    // Reference: extend each operand to 64 bits per its signedness and
    // multiply modulo 2^64; the true product always fits in 64 bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic as_, input logic bs_, input logic hi);
        logic [63:0] ea, eb, p;
        ea = as_ ? {{32{a[31]}}, a} : {32'd0, a};
        eb = bs_ ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return hi ? p[63:32] : p[31:0];
    endfunction

    function automatic int ref_latency(input logic hi);
`ifdef MUL_FAST_LOW_EN
        return hi ? 18 : 12;
`else
        return (hi == 1'b0) ? 18 : 18;
`endif
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle (or in its valid cycle).
    // Drives a request, counts cycles to valid_o and checks the result.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic as_, input logic bs_, input logic hi,
                         input logic [31:0] exp, input string tag);
        int k;
        bit got;
        op_a_i = a; op_b_i = b; a_signed_i = as_; b_signed_i = bs_; high_i = hi;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        k = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk_i);
            k++;
            if (valid_o) got = 1'b1;
        end
        check_int({tag, " latency"}, got ? k : -1, ref_latency(hi));
        check32({tag, " result"}, result_o, exp);
        check32({tag, " busy_at_valid"}, {31'd0, busy_o}, 32'd0);
        $display("op %-10s a=%h b=%h as=%0b bs=%0b hi=%0b -> result=%h (exp %h) cycles=%0d",
                 tag, a, b, as_, bs_, hi, result_o, exp, k);
        last_res = exp;
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0;
        op_a_i = '0; op_b_i = '0; a_signed_i = 1'b0; b_signed_i = 1'b0; high_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        check32("reset busy",   {31'd0, busy_o},  32'd0);
        check32("reset valid",  {31'd0, valid_o}, 32'd0);
        check32("reset result", result_o,         32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed cases
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, "mulhu_max");
        @(negedge clk_i);
        check32("valid_drop", {31'd0, valid_o}, 32'd0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h4000_0000, "mulh_min");
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, "mul_min");
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, "mulhsu_hi");
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, "mulhsu_lo");
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0, 32'h242D_2080, "mul_mix");
        @(negedge clk_i);

        // Kill in cycle N+5 with a coincident start, then a start the next cycle
        op_a_i = 32'h1234_5678; op_b_i = 32'h9ABC_DEF0;
        a_signed_i = 1'b0; b_signed_i = 1'b0; high_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check32("kill busy_before", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1; start_i = 1'b1;
        op_a_i = 32'h0000_0003; op_b_i = 32'h0000_0005;
        @(posedge clk_i);
        #1 kill_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check32("kill busy_after", {31'd0, busy_o},  32'd0);
        check32("kill valid",      {31'd0, valid_o}, 32'd0);
        check32("kill result_hold", result_o, last_res);
        do_op(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 32'hEADB_EEF0, "after_kill");

        // Back-to-back: second start driven in the valid cycle of the first
        do_op(32'h0000_1000, 32'h0010_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0001, "b2b_first");
        do_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFA, "b2b_second");
        @(negedge clk_i);

        // Randomized operations against the reference model
        for (int n = 0; n < 24; n++) begin
            logic [31:0] ra, rb;
            logic        rs_a, rs_b, rh;
            ra   = $urandom;
            rb   = $urandom;
            if (n % 6 == 0) ra = 32'h8000_0000;
            if (n % 7 == 3) rb = 32'hFFFF_FFFF;
            rs_a = 1'($urandom_range(0, 1));
            rs_b = 1'($urandom_range(0, 1));
            rh   = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs_a, rs_b, rh, ref_mul(ra, rb, rs_a, rs_b, rh), "random");
        end
        @(negedge clk_i);

        // Asynchronous reset mid-CALC
        op_a_i = 32'h7654_3210; op_b_i = 32'h0BAD_F00D;
        a_signed_i = 1'b1; b_signed_i = 1'b0; high_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (6) @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check32("async_rst busy",   {31'd0, busy_o},  32'd0);
        check32("async_rst valid",  {31'd0, valid_o}, 32'd0);
        check32("async_rst result", result_o,         32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_op(32'h7654_3210, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1,
              ref_mul(32'h7654_3210, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1), "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul32_seq_byte
